// File: rtl/tiny_calc_pkg.sv
// Shared types and constants for the tiny_calculator operand entry front end.
package tiny_calc_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    SHOW    = 2'd2
  } entry_state_t;

  localparam logic [1:0] LEDR_ENTER_A = 2'b01;
  localparam logic [1:0] LEDR_ENTER_B = 2'b10;
  localparam logic [1:0] LEDR_SHOW    = 2'b11;

  // LED pattern shown for each entry state.
  function automatic logic [1:0] ledr_for(input entry_state_t st);
    logic [1:0] led;
    led = LEDR_ENTER_A;
    case (st)
      ENTER_A: led = LEDR_ENTER_A;
      ENTER_B: led = LEDR_ENTER_B;
      SHOW:    led = LEDR_SHOW;
      default: led = LEDR_ENTER_A;
    endcase
    return led;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Conditions one raw active-low pushbutton: 2-FF synchronizer, hold-time
// debounce filter and a one-cycle pulse on each accepted press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pressed_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             level_prev_q, level_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // Next-state: synchronize, count disagreeing cycles, flip the level once
  // it has disagreed long enough, and flag the registered 1->0 transition.
  always_comb begin
    sync1_d      = key_n;
    sync2_d      = sync1_q;
    level_d      = level_q;
    cnt_d        = '0;
    level_prev_d = level_q;
    pulse_d      = level_prev_q & ~level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; reset presents a released, idle key.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      level_q      <= 1'b1;
      level_prev_q <= 1'b1;
      cnt_q        <= '0;
      pulse_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      cnt_q        <= cnt_d;
      pulse_q      <= pulse_d;
    end
  end

  assign pressed_pulse = pulse_q;

endmodule

// File: rtl/tiny_operand_entry.sv
// Two-operand entry front end: commits SW as operand A then B on debounced
// ENTER presses and holds {B, A} stable for tiny_calculator.
module tiny_operand_entry
  import tiny_calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NIBBLE_W-1:0]   SW,
  input  logic                  KEY_ENTER,
  input  logic                  KEY_CLEAR,
  output logic [2*NIBBLE_W-1:0] OPERANDS,
  output logic                  VALID,
  output logic [1:0]            LEDR
);

  // Index 0 = enter, index 1 = clear.
  logic [1:0] key_n_raw;
  logic [1:0] press;

  assign key_n_raw = {KEY_CLEAR, KEY_ENTER};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_n        (key_n_raw[gi]),
        .pressed_pulse(press[gi])
      );
    end
  endgenerate

  entry_state_t        state_q, state_d;
  logic [NIBBLE_W-1:0] a_q, a_d;
  logic [NIBBLE_W-1:0] b_q, b_d;
  logic                valid_q, valid_d;
  logic [1:0]          ledr_q, ledr_d;

  // Entry FSM: clear beats enter; SHOW + enter starts a fresh pair with A.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    if (press[1]) begin
      a_d     = '0;
      b_d     = '0;
      valid_d = 1'b0;
      state_d = ENTER_A;
    end else if (press[0]) begin
      case (state_q)
        ENTER_A, SHOW: begin
          a_d     = SW;
          b_d     = '0;
          valid_d = 1'b0;
          state_d = ENTER_B;
        end
        ENTER_B: begin
          b_d     = SW;
          valid_d = 1'b1;
          state_d = SHOW;
        end
        default: begin
          a_d     = '0;
          b_d     = '0;
          valid_d = 1'b0;
          state_d = ENTER_A;
        end
      endcase
    end
    ledr_d = ledr_for(state_d);
  end

  // Operand, state and indicator registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      ledr_q  <= LEDR_ENTER_A;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      ledr_q  <= ledr_d;
    end
  end

  assign OPERANDS = {b_q, a_q};
  assign VALID    = valid_q;
  assign LEDR     = ledr_q;

endmodule

// File: tb/tb_tiny_operand_entry.sv
// Self-checking bench for tiny_operand_entry with DEBOUNCE_CYCLES = 4.
module tb_tiny_operand_entry;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] SW;
  logic       KEY_ENTER;
  logic       KEY_CLEAR;
  logic [7:0] OPERANDS;
  logic       VALID;
  logic [1:0] LEDR;

  tiny_operand_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SW       (SW),
    .KEY_ENTER(KEY_ENTER),
    .KEY_CLEAR(KEY_CLEAR),
    .OPERANDS (OPERANDS),
    .VALID    (VALID),
    .LEDR     (LEDR)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: raw key samples per edge, accepted level, pending press
  // countdowns, and the operand pair / entry phase (0=A, 1=B, 2=show).
  bit         q_e[$];
  bit         q_c[$];
  bit         lvl_e, lvl_c;
  int         cd_e, cd_c;
  logic [3:0] m_a, m_b;
  logic       m_valid;
  int         m_phase;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // A key level is accepted once the synchronized samples (two edges late)
  // have disagreed with the current level for D consecutive edges.
  function automatic bit window_differs(input bit q[$], input bit lvl);
    if (q.size() < D + 2) return 1'b0;
    for (int i = 0; i < D; i++)
      if (q[q.size() - 3 - i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [1:0] m_ledr();
    return (m_phase == 0) ? 2'b01 : (m_phase == 1) ? 2'b10 : 2'b11;
  endfunction

  task automatic model_edge(input bit en_n, input bit cl_n, input logic [3:0] sw, input bit rst);
    bit fe, fc;
    if (rst) begin
      m_a = 4'h0; m_b = 4'h0; m_valid = 1'b0; m_phase = 0;
      q_e = '{1'b1, 1'b1};
      q_c = '{1'b1, 1'b1};
      lvl_e = 1'b1; lvl_c = 1'b1;
      cd_e = 0; cd_c = 0;
      return;
    end
    fe = (cd_e == 1);
    fc = (cd_c == 1);
    if (cd_e > 0) cd_e--;
    if (cd_c > 0) cd_c--;
    if (fc) begin
      m_a = 4'h0; m_b = 4'h0; m_valid = 1'b0; m_phase = 0;
    end else if (fe) begin
      if (m_phase == 1) begin
        m_b = sw; m_valid = 1'b1; m_phase = 2;
      end else begin
        m_a = sw; m_b = 4'h0; m_valid = 1'b0; m_phase = 1;
      end
    end
    q_e.push_back(en_n);
    q_c.push_back(cl_n);
    if (window_differs(q_e, lvl_e)) begin
      lvl_e = ~lvl_e;
      if (!lvl_e) cd_e = 2;
    end
    if (window_differs(q_c, lvl_c)) begin
      lvl_c = ~lvl_c;
      if (!lvl_c) cd_c = 2;
    end
    if (q_e.size() > D + 4) void'(q_e.pop_front());
    if (q_c.size() > D + 4) void'(q_c.pop_front());
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare.
  task automatic step(input bit en_n, input bit cl_n, input logic [3:0] sw, input bit rst);
    KEY_ENTER = en_n;
    KEY_CLEAR = cl_n;
    SW        = sw;
    rst_n     = ~rst;
    @(posedge clk);
    model_edge(en_n, cl_n, sw, rst);
    #1;
    check("model_operands", {24'h0, OPERANDS}, {24'h0, m_b, m_a});
    check("model_valid", {31'h0, VALID}, {31'h0, m_valid});
    check("model_ledr", {30'h0, LEDR}, {30'h0, m_ledr()});
  endtask

  task automatic press(input logic [3:0] sw, input bit en, input bit cl, input int low, input int high);
    for (int i = 0; i < low; i++) step(!en, !cl, sw, 1'b0);
    for (int i = 0; i < high; i++) step(1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'b0);
  endtask

  typedef struct {
    logic [3:0] sw;
    bit         en;
    bit         cl;
    int         low;
    int         high;
    logic [7:0] ops;
    logic       valid;
    logic [1:0] ledr;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit         le, lc, rr;
    int         run_e, run_c;
    logic [3:0] sw_r;

    KEY_ENTER = 1'b1; KEY_CLEAR = 1'b1; SW = 4'h0; rst_n = 1'b0;

    vecs[0] = '{4'h2, 1'b1, 1'b0, 10, 10, 8'h23, 1'b1, 2'b11};
    vecs[1] = '{4'hE, 1'b1, 1'b0,  3, 10, 8'h23, 1'b1, 2'b11};
    vecs[2] = '{4'hE, 1'b1, 1'b0, 10, 10, 8'h0E, 1'b0, 2'b10};
    vecs[3] = '{4'h0, 1'b0, 1'b1, 10, 10, 8'h00, 1'b0, 2'b01};
    vecs[4] = '{4'h8, 1'b1, 1'b0, 10, 10, 8'h08, 1'b0, 2'b10};
    vecs[5] = '{4'h9, 1'b1, 1'b1, 40, 10, 8'h00, 1'b0, 2'b01};
    vecs[6] = '{4'hF, 1'b1, 1'b0, 10, 10, 8'h0F, 1'b0, 2'b10};
    vecs[7] = '{4'hF, 1'b1, 1'b0, 10, 10, 8'hFF, 1'b1, 2'b11};
    vecs[8] = '{4'hF, 1'b1, 1'b0, 50, 10, 8'h0F, 1'b0, 2'b10};

    // Reset, then idle.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'h0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'b0);
    check("idle_operands", {24'h0, OPERANDS}, 32'h00);
    check("idle_valid", {31'h0, VALID}, 32'h0);
    check("idle_ledr", {30'h0, LEDR}, 32'h1);

    // First press: commit lands exactly at edge D+4 after the first low sample.
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1, 4'h3, 1'b0);
      if (i == D + 3) check("latency_before", {24'h0, OPERANDS}, 32'h00);
      if (i == D + 4) begin
        check("latency_at", {24'h0, OPERANDS}, 32'h03);
        check("latency_ledr", {30'h0, LEDR}, 32'h2);
      end
    end
    press(4'h3, 1'b0, 1'b0, 0, 10);

    // Table of press/hold scenarios with fixed expected results.
    for (int v = 0; v < 9; v++) begin
      press(vecs[v].sw, vecs[v].en, vecs[v].cl, vecs[v].low, vecs[v].high);
      check($sformatf("vec%0d_operands", v), {24'h0, OPERANDS}, {24'h0, vecs[v].ops});
      check($sformatf("vec%0d_valid", v), {31'h0, VALID}, {31'h0, vecs[v].valid});
      check($sformatf("vec%0d_ledr", v), {30'h0, LEDR}, {30'h0, vecs[v].ledr});
    end

    // Reset mid-debounce, then keep holding: one press after a full hold.
    step(1'b0, 1'b1, 4'h5, 1'b0);
    step(1'b0, 1'b1, 4'h5, 1'b0);
    step(1'b0, 1'b1, 4'h5, 1'b1);
    check("rst_mid_operands", {24'h0, OPERANDS}, 32'h00);
    check("rst_mid_valid", {31'h0, VALID}, 32'h0);
    check("rst_mid_ledr", {30'h0, LEDR}, 32'h1);
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1, 4'h5, 1'b0);
      if (i == D + 3) check("rst_hold_before", {24'h0, OPERANDS}, 32'h00);
      if (i == D + 4) check("rst_hold_at", {24'h0, OPERANDS}, 32'h05);
    end
    check("rst_hold_ledr", {30'h0, LEDR}, 32'h2);
    press(4'h5, 1'b0, 1'b0, 0, 10);

    // Randomized key activity against the reference model.
    le = 1'b1; lc = 1'b1; run_e = 3; run_c = 20; sw_r = 4'h0;
    for (int i = 0; i < 1500; i++) begin
      if (run_e == 0) begin
        le = ~le;
        run_e = $urandom_range(1, 12);
      end
      if (run_c == 0) begin
        lc = ~lc;
        run_c = lc ? $urandom_range(10, 60) : $urandom_range(1, 8);
      end
      if ($urandom_range(0, 3) == 0) sw_r = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 299) == 0);
      step(le, lc, sw_r, rr);
      run_e--;
      run_c--;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
